sum_serie_nb: RTL and testbench
===============================

SUM_SERIE_NB -- requirements
Module: sum_serie_nb

Interface
REQ-001 Parameter WIDTH, default 16, total operand/result width in bits; SHALL be a multiple of CHUNK, at least CHUNK.
REQ-002 Parameter CHUNK, default 4, bits added per cycle; SHALL be at least 1.
REQ-003 Derived constant NCHUNK = WIDTH/CHUNK, the number of compute cycles per operation.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  request a new operation; sampled only in IDLE.
REQ-007 A  input  WIDTH  operand A; sampled on the accepted start cycle.
REQ-008 B  input  WIDTH  operand B; sampled on the accepted start cycle.
REQ-009 Cn  input  1  carry-in; sampled on the accepted start cycle.
REQ-010 op  input  1  0 = add, 1 = subtract; present only with SUM_SUB_EN.
REQ-011 busy  output  1  high while an operation is in progress (CALC or FIN).
REQ-012 done  output  1  one-cycle pulse; result valid.
REQ-013 S  output  WIDTH  result.
REQ-014 Co  output  1  carry out of the MSB (for subtract, 1 = no borrow).
REQ-015 ovf  output  1  two's-complement overflow.

Function
REQ-016 The FSM SHALL have three states: IDLE, CALC and FIN.
REQ-017 IDLE with start=1: latch A, B' and carry c, clear chunk index k to 0, and go to CALC. B' = B and c = Cn for add; B' = ~B and c = 1 for subtract, with Cn ignored.
REQ-018 CALC: each cycle, add chunk k of A and B' plus c, write the sum into chunk k of the internal accumulator, set c to the chunk carry, and increment k.
REQ-019 CALC at k = NCHUNK-1: copy the accumulator to S, set Co to the final carry, set ovf = carry-into-MSB XOR carry-out, and go to FIN.
REQ-020 FIN: done=1 for exactly this cycle, then return to IDLE unconditionally.
REQ-021 Latency: an accepted start in cycle t gives done=1 in cycle t+NCHUNK+1; throughput is one operation per NCHUNK+2 cycles.
REQ-022 start while busy=1 (CALC or FIN) SHALL be ignored: no latch and no queuing.
REQ-023 A, B, Cn and op changing after acceptance SHALL NOT affect the in-flight result.
REQ-024 S, Co and ovf SHALL change only on the edge that enters FIN, and SHALL hold their values until the next FIN.
REQ-025 Wrap-around is modulo 2^WIDTH; the carry out is reported only on Co.

Reset
REQ-026 rst=1 SHALL force the state to IDLE and set k=0, c=0, busy=0, done=0, S=0, Co=0, ovf=0 and the accumulator to 0.
REQ-027 rst asserted during CALC or FIN SHALL abort the operation; no done pulse SHALL follow.
REQ-028 rst has priority over start in the same cycle.

Configuration
REQ-029 Macro SUM_SUB_EN defined: the op port exists and subtract follows REQ-017.
REQ-030 Macro SUM_SUB_EN undefined: the op port is absent, the block SHALL always add using Cn, and no subtract logic is synthesised.

Structure
REQ-031 Package sum_pkg SHALL hold the FSM state typedef (IDLE, CALC, FIN) and the default WIDTH and CHUNK constants.
REQ-032 Sub-module sum_tramo SHALL be a combinational CHUNK-bit ripple adder built from FA cells.
	- Ports: chunk A, chunk B, carry-in.
	- Outputs: chunk sum, carry out, carry into the chunk MSB (used for ovf).
REQ-033 sum_serie_nb SHALL instantiate exactly one sum_tramo and select chunk k by index.

Verification (WIDTH=16, CHUNK=4)
REQ-034 Add 0xFFFF + 0x0001, Cn=0, start at cycle 0 -> S=0x0000, Co=1, ovf=0, done=1 at cycle 5, busy=1 in cycles 1-5.
REQ-035 Add 0x1234 + 0x4321, Cn=1 -> S=0x5556, Co=0, ovf=0.
REQ-036 Add 0x7FFF + 0x0001, Cn=0 -> S=0x8000, Co=0, ovf=1.
REQ-037 With SUM_SUB_EN, op=1: 0x0005 - 0x0007 -> S=0xFFFE, Co=0, ovf=0; and 0x8000 - 0x0001 -> S=0x7FFF, Co=1, ovf=1.
REQ-038 start pulsed again at cycle 2 of an operation -> ignored; exactly one done, at cycle 5, carrying the original operands' result.
REQ-039 rst asserted at cycle 3 of an operation -> IDLE at cycle 4, busy=0, S=0, and no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared constants and FSM state encoding for the serial chunked adder.
// Optional subtract support is enabled with the SUM_SUB_EN macro.
package sum_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t FIN  = 2'd2;

endpackage

// File: rtl/sum_tramo.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells; also exposes
// the carry into the chunk MSB so the caller can derive two's-complement overflow.
module sum_tramo
    import sum_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/sum_serie_nb.sv
// Serial adder: processes CHUNK bits per cycle through a single sum_tramo.
// Define SUM_SUB_EN to add the op port and subtract support.
module sum_serie_nb
    import sum_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cn,
`ifdef SUM_SUB_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int K_W    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NCHUNK - 1);

    state_t           state;
    logic [K_W-1:0]   k;
    logic             c;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] b_sel;
    logic             c_sel;
    logic [CHUNK-1:0] sum_chunk;
    logic             c_out;
    logic             c_msb;

    // Subtraction is A + ~B + 1, so only the operand and carry selection differ.
    always_comb begin
`ifdef SUM_SUB_EN
        b_sel = op ? ~B : B;
        c_sel = op ? 1'b1 : Cn;
`else
        b_sel = B;
        c_sel = Cn;
`endif
    end

    sum_tramo #(
        .CHUNK (CHUNK)
    ) u_tramo (
        .a     (a_r[k*CHUNK +: CHUNK]),
        .b     (b_r[k*CHUNK +: CHUNK]),
        .ci    (c),
        .s     (sum_chunk),
        .co    (c_out),
        .c_msb (c_msb)
    );

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        acc_next = acc;
        acc_next[k*CHUNK +: CHUNK] = sum_chunk;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            c     <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            acc   <= '0;
            S     <= '0;
            Co    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= A;
                        b_r   <= b_sel;
                        c     <= c_sel;
                        k     <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    c   <= c_out;
                    if (k == K_LAST) begin
                        // The last chunk lands in S on the same edge it is computed.
                        S     <= acc_next;
                        Co    <= c_out;
                        ovf   <= c_msb ^ c_out;
                        k     <= '0;
                        state <= FIN;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CALC) || (state == FIN);
    assign done = (state == FIN);

endmodule

// File: tb/tb_sum_serie_nb.sv
// Scoreboard bench for sum_serie_nb (WIDTH=16, CHUNK=4); subtract cases run
// only when SUM_SUB_EN is defined for both bench and design.
module tb_sum_serie_nb;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cn;
    logic         op;
    logic         busy;
    logic         done;
    logic [W-1:0] S;
    logic         Co;
    logic         ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ops_cnt  = 0;
    exp_t sb[$];

    sum_serie_nb #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cn    (Cn),
`ifdef SUM_SUB_EN
        .op    (op),
`endif
        .busy  (busy),
        .done  (done),
        .S     (S),
        .Co    (Co),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cn, input logic o);
        exp_t         e;
        logic [W-1:0] bp;
        logic         ci;
        logic [W:0]   r;
        bp    = o ? ~b : b;
        ci    = o ? 1'b1 : cn;
        r     = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, ci};
        e.s   = r[W-1:0];
        e.co  = r[W];
        e.ovf = (a[W-1] == bp[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    // Results are compared whenever the DUT pulses done.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("S", 32'(S), 32'(e.s));
                check("Co", 32'(Co), 32'(e.co));
                check("ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    // One operation; cycle 0 is the start cycle. restart_at>0 pulses start mid-flight.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cn,
                         input logic o, input int restart_at);
        exp_t e;
        int   n;
        e = model(a, b, cn, o);
        @(posedge clk); #1;
        A = a; B = b; Cn = cn; op = o; start = 1'b1;
        sb.push_back(e);
        ops_cnt++;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (i == 1) begin
                start = 1'b0;
                A = W'($urandom); B = W'($urandom); Cn = 1'($urandom); op = 1'($urandom);
            end
            if (restart_at > 0 && i == restart_at) start = 1'b1;
            if (restart_at > 0 && i == restart_at + 1) start = 1'b0;
            if (done === 1'b1) begin
                n = i;
                break;
            end
            check("busy_calc", 32'(busy), 32'd1);
        end
        if (n == 0) begin
            check("done_timeout", 32'd0, 32'd1);
            start = 1'b0;
            return;
        end
        check("latency", 32'(n), 32'd5);
        check("busy_fin", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("busy_idle", 32'(busy), 32'd0);
        check("s_hold", 32'(S), 32'(e.s));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cn = 1'b0; op = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_S", 32'(S), 32'd0);
        check("rst_Co", 32'(Co), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0);
        do_op(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 2);
`ifdef SUM_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
        do_op(16'h1234, 16'h1234, 1'b0, 1'b1, 2);
`endif
        for (int r = 0; r < 6; r++) begin
`ifdef SUM_SUB_EN
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
`else
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 0);
`endif
        end

        // Reset at cycle 3 aborts the operation; no done must follow.
        @(posedge clk); #1;
        A = 16'h1111; B = 16'h2222; Cn = 1'b0; op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_S", 32'(S), 32'd0);
        check("abort_Co", 32'(Co), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(ops_cnt));

        do_op(16'hABCD, 16'h1357, 1'b1, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("done_count", 32'(done_cnt), 32'(ops_cnt));
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
